// File: rtl/srt_mem_arbiter_pkg.sv
// Shared encodings for the sort-memory arbiter: FSM states and the
// owner code remembered for tie-breaking.
package srt_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_HOST = 2'd2
    } state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_SORT = 1'b1
    } owner_t;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/srt_mem_arbiter_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module srt_mem_arbiter_sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/srt_mem_arbiter.sv
// Owns the sort RAM port: whole-sort grants for the sorter, bounded host
// bursts, registered host read-back and a sort-duration counter.
module srt_mem_arbiter
    import srt_mem_arbiter_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int HBURST = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_req,
    output logic          s_gnt,
    input  logic [AW-1:0] s_a,
    input  logic [AW-1:0] s_dpra,
    input  logic [DW-1:0] s_d,
    input  logic          s_we,
    input  logic          h_req,
    output logic          h_gnt,
    input  logic [AW-1:0] h_a,
    input  logic [DW-1:0] h_d,
    input  logic          h_we,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    output logic [AW-1:0] m_a,
    output logic [AW-1:0] m_dpra,
    output logic [DW-1:0] m_d,
    output logic          m_we,
    input  logic [DW-1:0] m_spo,
    input  logic [DW-1:0] m_dpo,
    output logic [31:0]   sort_cycles,
    output logic          cyc_valid
);

    localparam int           HW   = cnt_width(HBURST - 1);
    localparam logic [HW-1:0] HMAX = HW'(HBURST - 1);

    state_t        state, state_nxt;
    owner_t        last;
    logic [HW-1:0] hcnt;
    logic [31:0]   cyc;
    logic          host_entry, sort_entry, sort_exit, host_exit;

    // Second read port data is routed to the sorter outside this block.
    logic unused_dpo;
    assign unused_dpo = ^m_dpo;

    assign host_entry = (state != ST_HOST) && (state_nxt == ST_HOST);
    assign sort_entry = (state != ST_SORT) && (state_nxt == ST_SORT);
    assign sort_exit  = (state == ST_SORT) && (state_nxt == ST_IDLE);
    assign host_exit  = (state == ST_HOST) && (state_nxt == ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_req && h_req)
                    state_nxt = (last == OWN_SORT) ? ST_HOST : ST_SORT;
                else if (s_req)
                    state_nxt = ST_SORT;
                else if (h_req)
                    state_nxt = ST_HOST;
            end
            ST_SORT: if (!s_req) state_nxt = ST_IDLE;
            // A waiting sorter cuts the burst once the host has used its quota.
            ST_HOST: if (!h_req || (s_req && hcnt == HMAX)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_gnt  = (state == ST_SORT);
        h_gnt  = (state == ST_HOST);
        m_a    = '0;
        m_dpra = '0;
        m_d    = '0;
        m_we   = 1'b0;
        case (state)
            ST_SORT: begin
                m_a    = s_a;
                m_dpra = s_dpra;
                m_d    = s_d;
                m_we   = s_we & s_req;
            end
            ST_HOST: begin
                m_a    = h_a;
                m_dpra = h_a;
                m_d    = h_d;
                m_we   = h_we & h_req;
            end
            default: ;
        endcase
    end

    srt_mem_arbiter_sat_counter #(.W(HW), .MAX(HMAX)) u_hcnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (host_entry),
        .en   (state == ST_HOST),
        .cnt  (hcnt)
    );

    srt_mem_arbiter_sat_counter #(.W(32), .MAX('1)) u_cyc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (sort_entry),
        .en   (state == ST_SORT),
        .cnt  (cyc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last        <= OWN_HOST;
            h_rdata     <= '0;
            h_rvalid    <= 1'b0;
            sort_cycles <= '0;
            cyc_valid   <= 1'b0;
        end else begin
            if (sort_exit)
                last <= OWN_SORT;
            else if (host_exit)
                last <= OWN_HOST;

            h_rvalid <= (state == ST_HOST) && h_req && !h_we;
            if ((state == ST_HOST) && h_req && !h_we)
                h_rdata <= m_spo;

            // The exit cycle is itself a sort cycle, so report the post-increment count.
            if (sort_exit) begin
                sort_cycles <= (cyc == '1) ? cyc : cyc + 32'd1;
                cyc_valid   <= 1'b1;
            end else if (sort_entry) begin
                cyc_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srt_mem_arbiter.sv
// Bench for srt_mem_arbiter: per-cycle grant/mux vectors plus a queue of
// expected host read data checked when h_rvalid comes back.
module tb_srt_mem_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int HBURST = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_req, s_gnt, s_we, h_req, h_gnt, h_we, h_rvalid, m_we, cyc_valid;
    logic [AW-1:0] s_a, s_dpra, h_a, m_a, m_dpra;
    logic [DW-1:0] s_d, h_d, h_rdata, m_d, m_spo, m_dpo;
    logic [31:0]   sort_cycles;

    srt_mem_arbiter #(.AW(AW), .DW(DW), .HBURST(HBURST)) dut (
        .clk(clk), .rstn(rstn),
        .s_req(s_req), .s_gnt(s_gnt), .s_a(s_a), .s_dpra(s_dpra), .s_d(s_d), .s_we(s_we),
        .h_req(h_req), .h_gnt(h_gnt), .h_a(h_a), .h_d(h_d), .h_we(h_we),
        .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .m_a(m_a), .m_dpra(m_dpra), .m_d(m_d), .m_we(m_we), .m_spo(m_spo), .m_dpo(m_dpo),
        .sort_cycles(sort_cycles), .cyc_valid(cyc_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(32'hC0DE0000 + i * 3);
    endfunction

    // Distributed RAM model: async read, write on the clock edge.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic          mem_ready = 1'b0;
    assign m_spo = mem[m_a];
    assign m_dpo = mem[m_dpra];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (m_we) begin
            mem[m_a] <= m_d;
        end
    end

    typedef struct {
        logic          sr, sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          hr, hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          es, eh;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] sbq [$];

    function automatic vec_t mk(input logic sr, input logic sw, input logic [AW-1:0] sa,
                                input logic [DW-1:0] sd, input logic hr, input logic hw,
                                input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                                input logic es, input logic eh);
        vec_t v;
        v.sr = sr; v.sw = sw; v.sa = sa; v.sd = sd;
        v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.es = es; v.eh = eh;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle, check grant/mux, track writes,
    // queue expected read data, then check read-back after the rising edge.
    task automatic step(input vec_t v, input string tag);
        logic          ew, rd;
        logic [AW-1:0] ea, edp;
        logic [DW-1:0] ed, exp_rd;
        s_req = v.sr; s_we = v.sw; s_a = v.sa; s_d = v.sd; s_dpra = ~v.sa;
        h_req = v.hr; h_we = v.hw; h_a = v.ha; h_d = v.hd;
        #1;
        ew  = v.es ? (v.sw & v.sr) : (v.eh ? (v.hw & v.hr) : 1'b0);
        ea  = v.es ? v.sa : (v.eh ? v.ha : '0);
        edp = v.es ? ~v.sa : (v.eh ? v.ha : '0);
        ed  = v.es ? v.sd : (v.eh ? v.hd : '0);
        chk1({tag, " s_gnt"}, s_gnt, v.es);
        chk1({tag, " h_gnt"}, h_gnt, v.eh);
        chk1({tag, " m_we"}, m_we, ew);
        chkw({tag, " m_a"}, DW'(m_a), DW'(ea));
        chkw({tag, " m_dpra"}, DW'(m_dpra), DW'(edp));
        chkw({tag, " m_d"}, m_d, ed);
        if (ew) ref_mem[ea] = ed;
        rd = v.eh && v.hr && !v.hw;
        if (rd) sbq.push_back(ref_mem[v.ha]);
        @(posedge clk);
        #1;
        chk1({tag, " h_rvalid"}, h_rvalid, rd);
        if (rd) begin
            exp_rd = sbq.pop_front();
            if (h_rvalid) chkw({tag, " h_rdata"}, h_rdata, exp_rd);
        end
        @(negedge clk);
    endtask

    vec_t tbl [14];

    initial begin
        // host write/read, gated drop, tie -> sorter, host write blocked during sort
        tbl[0]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b1, 8'd3,  32'h55,   1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b1, 8'd3,  32'h55,   1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd3,  32'h0,    1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b1, 8'd3,  32'hAA,   1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 8'd10, 32'h1234, 1'b1, 1'b1, 8'd3,  32'hDEAD, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 8'd11, 32'h9999, 1'b1, 1'b1, 8'd3,  32'hDEAD, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd3,  32'h0,    1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd3,  32'h0,    1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd10, 32'h0,    1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b1, 1'b0, 8'd11, 32'h0,    1'b0, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0, 8'd0,  32'h0,    1'b0, 1'b0);

        rstn = 1'b0;
        s_req = 1'b0; s_we = 1'b0; s_a = '0; s_dpra = '0; s_d = '0;
        h_req = 1'b0; h_we = 1'b0; h_a = '0; h_d = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk1("rst s_gnt", s_gnt, 1'b0);
        chk1("rst h_gnt", h_gnt, 1'b0);
        chk1("rst h_rvalid", h_rvalid, 1'b0);
        chk1("rst cyc_valid", cyc_valid, 1'b0);
        chk1("rst m_we", m_we, 1'b0);
        chkw("rst h_rdata", h_rdata, '0);
        chkw("rst sort_cycles", sort_cycles, '0);
        chkw("rst m_a", DW'(m_a), '0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("t%0d", i));

        // s_req arrives in host cycle 2: host keeps exactly HBURST cycles
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd20, 32'h0, 1'b0, 1'b0), "b_idle");
        for (int i = 1; i <= HBURST; i++)
            step(mk(i >= 2, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, AW'(20 + i), 32'h0, 1'b0, 1'b1),
                 $sformatf("burst%0d", i));
        step(mk(1'b1, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "b_gap");

        // 100-cycle sort, writes on odd cycles, host waiting throughout
        for (int k = 0; k < 100; k++)
            step(mk(k < 99, k[0], AW'(100 + k), DW'(k * 7 + 1), 1'b1, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0),
                 $sformatf("sort%0d", k));
        chk1("sort100 cyc_valid", cyc_valid, 1'b1);
        chkw("sort100 sort_cycles", sort_cycles, 32'd100);
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd101, 32'h0, 1'b0, 1'b0), "s_idle");

        // read-back, then the host alone runs past HBURST (hcnt saturates)
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd101, 32'h0, 1'b0, 1'b1), "rb101");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd100, 32'h0, 1'b0, 1'b1), "rb100");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd199, 32'h0, 1'b0, 1'b1), "rb199");
        for (int i = 4; i <= 20; i++)
            step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd20, 32'h0, 1'b0, 1'b1),
                 $sformatf("hold%0d", i));
        step(mk(1'b1, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd20, 32'h0, 1'b0, 1'b1), "sat21");
        step(mk(1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "sat_gap");

        // short sort leaves last=sorter, then a second sort is reset midway
        step(mk(1'b1, 1'b1, 8'd50, 32'h5050, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0), "ss1");
        chk1("ss cyc_valid clr", cyc_valid, 1'b0);
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0), "ss2");
        chk1("ss cyc_valid", cyc_valid, 1'b1);
        chkw("ss sort_cycles", sort_cycles, 32'd2);
        step(mk(1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "ss_idle");
        step(mk(1'b1, 1'b1, 8'd51, 32'h5151, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0), "rs1");
        s_req = 1'b1; s_we = 1'b1; s_a = 8'd250; s_d = 32'hBAD0BAD0; h_req = 1'b1;
        #1;
        chk1("pre-rst m_we", m_we, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("midrst s_gnt", s_gnt, 1'b0);
        chk1("midrst m_we", m_we, 1'b0);
        chk1("midrst cyc_valid", cyc_valid, 1'b0);
        chkw("midrst sort_cycles", sort_cycles, '0);
        @(negedge clk);
        rstn = 1'b1;
        step(mk(1'b1, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "rtie");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0), "rtie_s");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "r_idle");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd250, 32'h0, 1'b0, 1'b1), "rb250");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd50, 32'h0, 1'b0, 1'b1), "rb50");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 8'd51, 32'h0, 1'b0, 1'b1), "rb51");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1), "h_drop");
        step(mk(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0), "end_idle");

        chkw("scoreboard drained", DW'(sbq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srt_mem_arbiter.md
# srt_mem_arbiter

Arbitrates the single sort memory between the sorter datapath/control unit and a host/debug port used to load and inspect data. The sorter owns the memory for a whole sort; the host gets bounded bursts of single-cycle accesses. The block also measures sort duration in cycles for on-board display. It sits between the top level, the sorter and the distributed sort RAM (`a/d/we/spo`, `dpra/dpo`).

## Interface
- `AW`, 8: memory address width.
- `DW`, 32: memory data width.
- `HBURST`, 16: maximum consecutive host-granted cycles while the sorter is waiting; must be ≥ 1.

- `clk` input 1: system clock.
- `rstn` input 1: reset, asynchronous assert, active-low.
- `s_req` input 1: sorter request, level; held for the entire sort.
- `s_gnt` output 1: sorter owns the memory.
- `s_a`, `s_dpra` input AW: sorter write/read port address and second read port address.
- `s_d` input DW: sorter write data.
- `s_we` input 1: sorter write enable.
- `h_req` input 1: host request, level.
- `h_gnt` output 1: host owns the memory.
- `h_a` input AW: host address.
- `h_d` input DW: host write data.
- `h_we` input 1: host write enable.
- `h_rdata` output DW: registered `m_spo` from the previous granted host cycle.
- `h_rvalid` output 1: `h_rdata` is valid.
- `m_a`, `m_dpra` output AW: memory addresses.
- `m_d` output DW: memory write data.
- `m_we` output 1: memory write enable.
- `m_spo`, `m_dpo` input DW: asynchronous memory read data. `m_dpo` is passed through to the sorter by the top level and is not used here.
- `sort_cycles` output 32: duration of the last completed sorter ownership.
- `cyc_valid` output 1: `sort_cycles` is valid.

## Operation
- States:
  - IDLE: no owner.
  - SORT: sorter owns the memory.
  - HOST: host owns the memory.
- `s_gnt` is 1 exactly when the state is SORT. `h_gnt` is 1 exactly when the state is HOST. Both are decoded from the registered state only.
- IDLE transitions:
  - Only `s_req` is high: go to SORT.
  - Only `h_req` is high: go to HOST.
  - Both are high: the requester not recorded in `last` wins. `last` is a 1-bit register, reset value = host, so the sorter wins the first tie.
- SORT: stay while `s_req` is high. When `s_req` drops, go to IDLE and set `last` = sorter. A sort is never preempted.
- HOST: stay while `h_req` is high, with one exception. If `s_req` is high and `hcnt` = HBURST−1, go to IDLE. Either way, leaving HOST sets `last` = host.
  - `hcnt` counts granted host cycles. It clears on entry to HOST and saturates at HBURST−1.
  - When `h_req` drops, go to IDLE.
- Memory mux:
  - SORT: `m_a`=`s_a`, `m_dpra`=`s_dpra`, `m_d`=`s_d`, `m_we`=`s_we & s_req`.
  - HOST: `m_a`=`h_a`, `m_dpra`=`h_a`, `m_d`=`h_d`, `m_we`=`h_we & h_req`.
  - IDLE: all memory outputs are 0.
  - Gating `m_we` with `req` blocks writes in the one grant cycle that follows a request drop.
- Host read: in each HOST cycle with `h_req`=1 and `h_we`=0, `h_rdata` latches `m_spo` and `h_rvalid`=1 on the next cycle. Otherwise `h_rvalid`=0. `h_rdata` holds its last value.
- Cycle counter:
  - Clears to 0 on entry to SORT and increments on each SORT cycle, saturating at 2^32−1.
  - On SORT→IDLE, the count is copied to `sort_cycles` and `cyc_valid`=1.
  - `cyc_valid` clears on the next entry to SORT.

## Timing
- Reset values:
  - State IDLE, `last` = host, `hcnt` = 0, counter = 0.
  - `s_gnt`, `h_gnt`, `h_rvalid`, `cyc_valid`, `m_we` = 0.
  - `h_rdata`, `sort_cycles` = 0.
  - Reset mid-sort or mid-burst aborts immediately; there is no write on the reset cycle.
- Grant latency: a request seen high at edge k in IDLE gives a grant during cycle k+1.
- Release: a request dropped before edge k leaves the grant high in cycle k (writes gated) and returns the state to IDLE after edge k.
- Worst-case sorter wait after asserting `s_req`: HBURST+2 cycles.
- Host read latency: address in cycle n, `h_rvalid`/`h_rdata` in cycle n+1.
- Between owners there is always at least one IDLE cycle; there is no direct SORT↔HOST transition.

## Structure
- Shared package/header holds the state encodings (IDLE=0, SORT=1, HOST=2, 2 bits) and the owner codes for `last`.
- A single module: a next-state/output always block plus registers.
- The optional sub-module `sat_counter` (parameterised width, clear/enable) is reused for both `hcnt` and the cycle counter.

## Test plan
- Reset, then `h_req`=1, `h_we`=1, `h_a`=3, `h_d`=0x55 for 1 cycle, then a read of address 3 → `h_gnt` high from the 2nd cycle, `h_rvalid`=1 with `h_rdata`=0x55 one cycle after the read address.
- `s_req` and `h_req` rise together after reset → `s_gnt` first. After `s_req` drops: 1 IDLE cycle, then `h_gnt`.
- Host holds `h_req`, and `s_req` rises at host cycle 2, with HBURST=16 → `h_gnt` falls after 16 host cycles, 1 IDLE cycle, then `s_gnt`.
- Sorter owns for exactly 100 cycles with `s_we` toggling → `sort_cycles`=100, `cyc_valid`=1. `m_we`=0 during the post-drop grant cycle and during IDLE.
- `rstn` pulsed low mid-sort → `s_gnt`, `m_we`, `cyc_valid` go 0 immediately, state IDLE, and the next tie goes to the sorter.
- Host writes with `h_we`=1 while `s_gnt`=1 → no memory write occurs; memory contents are unchanged.
